// File: rtl/vcu_ram_pkg.sv
// Shared constants and types for the VCU RAM port arbiter.
package vcu_ram_pkg;

  localparam int unsigned VCU_RAM_ADDR_W = 10;
  localparam int unsigned VCU_RAM_DATA_W = 512;

  typedef logic ram_req_id_t;

endpackage

// File: rtl/vcu_rr_arb2.sv
// Two-way round-robin arbiter; grants are combinational, the priority pointer is registered.
module vcu_rr_arb2
  import vcu_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  ram_req_id_t pri_q;
  ram_req_id_t pri_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Grant selection; the pointer moves past whoever was just served.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    pri_d  = pri_q;
    if (!rst) begin
      case (req)
        2'b01: begin
          gnt    = 2'b01;
          gnt_id = 1'b0;
        end
        2'b10: begin
          gnt    = 2'b10;
          gnt_id = 1'b1;
        end
        2'b11: begin
          gnt    = pri_q ? 2'b10 : 2'b01;
          gnt_id = pri_q;
        end
        default: begin
          gnt    = 2'b00;
          gnt_id = 1'b0;
        end
      endcase
      if (|gnt) begin
        pri_d = ~gnt_id;
      end
    end
  end

endmodule

// File: rtl/vcu_ram_port_arbiter.sv
// Shares one two-port RAM between two writers and two readers with independent
// round-robin arbitration; read data returns one cycle after grant.
module vcu_ram_port_arbiter
  import vcu_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = VCU_RAM_ADDR_W,
  parameter int unsigned DATA_W = VCU_RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_valid,
  input  logic              wr1_valid,
  output logic              wr0_ready,
  output logic              wr1_ready,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              rd0_valid,
  input  logic              rd1_valid,
  output logic              rd0_ready,
  output logic              rd1_ready,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd0_rvalid,
  output logic              rd1_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_r_data
);

  logic [1:0]  wr_gnt;
  logic [1:0]  rd_gnt;
  logic        wr_gnt_id;
  logic        rd_gnt_id;
  logic        rsp_vld_q;
  logic        rsp_vld_d;
  ram_req_id_t rsp_id_q;
  ram_req_id_t rsp_id_d;

  vcu_rr_arb2 u_wr_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({wr1_valid, wr0_valid}),
    .gnt    (wr_gnt),
    .gnt_id (wr_gnt_id)
  );

  vcu_rr_arb2 u_rd_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({rd1_valid, rd0_valid}),
    .gnt    (rd_gnt),
    .gnt_id (rd_gnt_id)
  );

  assign wr0_ready = wr_gnt[0];
  assign wr1_ready = wr_gnt[1];
  assign rd0_ready = rd_gnt[0];
  assign rd1_ready = rd_gnt[1];

  // Write port mux; idle value is zero so the RAM pins never see a stale requester.
  always_comb begin
    ram_w_en   = 1'b0;
    ram_w_addr = '0;
    ram_w_data = '0;
    if (|wr_gnt) begin
      ram_w_en   = 1'b1;
      ram_w_addr = wr_gnt_id ? wr1_addr : wr0_addr;
      ram_w_data = wr_gnt_id ? wr1_data : wr0_data;
    end
  end

  always_comb begin
    ram_r_en   = 1'b0;
    ram_r_addr = '0;
    if (|rd_gnt) begin
      ram_r_en   = 1'b1;
      ram_r_addr = rd_gnt_id ? rd1_addr : rd0_addr;
    end
  end

  // Remember which reader owns the data coming back next cycle.
  always_comb begin
    rsp_vld_d = |rd_gnt;
    rsp_id_d  = (|rd_gnt) ? ram_req_id_t'(rd_gnt_id) : rsp_id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  // A response in flight while reset is held is dropped, so gate the strobes with rst.
  assign rd0_rvalid = rsp_vld_q && !rst && (rsp_id_q == 1'b0);
  assign rd1_rvalid = rsp_vld_q && !rst && (rsp_id_q == 1'b1);
  assign rd_rdata   = ram_r_data;

endmodule

// File: tb/tb_vcu_ram_port_arbiter.sv
// Directed bench for vcu_ram_port_arbiter with a behavioural read-before-write RAM.
module tb_vcu_ram_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr0_valid, wr1_valid, wr0_ready, wr1_ready;
  logic [AW-1:0] wr0_addr, wr1_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic          rd0_valid, rd1_valid, rd0_ready, rd1_ready;
  logic [AW-1:0] rd0_addr, rd1_addr;
  logic          rd0_rvalid, rd1_rvalid;
  logic [DW-1:0] rd_rdata;
  logic          ram_w_en, ram_r_en;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_w_data, ram_r_data;

  logic [DW-1:0] mem [1024];

  typedef struct packed {
    int unsigned   cyc;
    logic          id;
    logic          chk;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          exp_q [$];
  logic [DW-1:0] shadow [int];
  int            checks = 0;
  int            errors = 0;
  int unsigned   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, read-before-write on a shared address.
  always @(posedge clk) begin
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
  end

  vcu_ram_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .wr0_valid  (wr0_valid),
    .wr1_valid  (wr1_valid),
    .wr0_ready  (wr0_ready),
    .wr1_ready  (wr1_ready),
    .wr0_addr   (wr0_addr),
    .wr1_addr   (wr1_addr),
    .wr0_data   (wr0_data),
    .wr1_data   (wr1_data),
    .rd0_valid  (rd0_valid),
    .rd1_valid  (rd1_valid),
    .rd0_ready  (rd0_ready),
    .rd1_ready  (rd1_ready),
    .rd0_addr   (rd0_addr),
    .rd1_addr   (rd1_addr),
    .rd0_rvalid (rd0_rvalid),
    .rd1_rvalid (rd1_rvalid),
    .rd_rdata   (rd_rdata),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_r_en   (ram_r_en),
    .ram_r_addr (ram_r_addr),
    .ram_r_data (ram_r_data)
  );

  function automatic logic [DW-1:0] pat(input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(a);
    return {16{w}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check grants and RAM pins mid-cycle, settle any due response,
  // queue the response for a granted read, then advance to just after the next edge.
  task automatic step(input logic [1:0] ew, input logic [1:0] er);
    rsp_t          h;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [DW-1:0] wd;
    @(negedge clk);
    wa = ew[1] ? wr1_addr : (ew[0] ? wr0_addr : '0);
    wd = ew[1] ? wr1_data : (ew[0] ? wr0_data : '0);
    ra = er[1] ? rd1_addr : (er[0] ? rd0_addr : '0);
    chk("wr_ready",   DW'({wr1_ready, wr0_ready}), DW'(ew));
    chk("rd_ready",   DW'({rd1_ready, rd0_ready}), DW'(er));
    chk("ram_w_en",   DW'(ram_w_en),   DW'(|ew));
    chk("ram_w_addr", DW'(ram_w_addr), DW'(wa));
    chk("ram_w_data", ram_w_data,      wd);
    chk("ram_r_en",   DW'(ram_r_en),   DW'(|er));
    chk("ram_r_addr", DW'(ram_r_addr), DW'(ra));
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc && !rst) begin
      h = exp_q.pop_front();
      chk("rvalid", DW'({rd1_rvalid, rd0_rvalid}), h.id ? DW'(2'b10) : DW'(2'b01));
      if (h.chk) chk("rd_rdata", rd_rdata, h.data);
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) void'(exp_q.pop_front());
      chk("rvalid_idle", DW'({rd1_rvalid, rd0_rvalid}), DW'(0));
    end
    if (|er) begin
      h.cyc  = cyc + 1;
      h.id   = er[1];
      h.chk  = shadow.exists(int'(ra));
      h.data = h.chk ? shadow[int'(ra)] : '0;
      exp_q.push_back(h);
    end
    if (|ew) shadow[int'(wa)] = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int n1;
    rst       = 1'b1;
    wr0_valid = 1'b1;  wr1_valid = 1'b1;
    rd0_valid = 1'b1;  rd1_valid = 1'b1;
    wr0_addr  = 10'h100; wr0_data = pat(32'h100);
    wr1_addr  = 10'h101; wr1_data = pat(32'h101);
    rd0_addr  = 10'h100; rd1_addr = 10'h101;
    @(posedge clk);
    #1;

    // Reset held with every request asserted
    repeat (3) step(2'b00, 2'b00);
    rst = 1'b0;
    step(2'b01, 2'b01);
    wr0_valid = 1'b0; wr1_valid = 1'b0; rd0_valid = 1'b0; rd1_valid = 1'b0;
    step(2'b00, 2'b00);

    // Write at top address, read it back through reader 1
    wr0_valid = 1'b1; wr0_addr = 10'h3FF; wr0_data = {16{32'hA5A5_0001}};
    step(2'b01, 2'b00);
    wr0_valid = 1'b0;
    rd1_valid = 1'b1; rd1_addr = 10'h3FF;
    step(2'b00, 2'b10);
    rd1_valid = 1'b0;
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);

    // Lone wr1 grant hands priority back to writer 0
    wr1_valid = 1'b1; wr1_addr = 10'h200; wr1_data = pat(32'h200);
    step(2'b10, 2'b00);
    wr1_valid = 1'b0;

    // Write contention, addresses 0..5 alternate between writers
    n0 = 0; n1 = 1;
    wr0_valid = 1'b1; wr1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr0_addr = AW'(n0); wr0_data = pat(n0);
      wr1_addr = AW'(n1); wr1_data = pat(n1);
      step((k % 2 == 1) ? 2'b10 : 2'b01, 2'b00);
      if (k % 2 == 0) n0 += 2;
      else            n1 += 2;
    end
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    rd0_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rd0_addr = AW'(k);
      step(2'b00, 2'b01);
    end
    rd0_valid = 1'b0;
    step(2'b00, 2'b00);

    // Same-cycle write and read of 0x010 returns the old word
    wr0_valid = 1'b1; wr0_addr = 10'h010; wr0_data = DW'(1);
    step(2'b01, 2'b00);
    wr0_data = DW'(2);
    rd0_valid = 1'b1; rd0_addr = 10'h010;
    step(2'b01, 2'b01);
    wr0_valid = 1'b0;
    step(2'b00, 2'b01);
    rd0_valid = 1'b0;
    step(2'b00, 2'b00);

    // Fill 0x020..0x023, then run both readers back to back
    wr0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr0_addr = AW'(32'h20 + k); wr0_data = pat(32'h20 + k);
      step(2'b01, 2'b00);
    end
    wr0_valid = 1'b0;
    rd1_valid = 1'b1; rd1_addr = 10'h020;
    step(2'b00, 2'b10);
    n0 = 32'h20; n1 = 32'h21;
    rd0_valid = 1'b1; rd1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd0_addr = AW'(n0); rd1_addr = AW'(n1);
      step(2'b00, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k % 2 == 0) n0 += 2;
      else            n1 += 2;
    end
    rd0_valid = 1'b0; rd1_valid = 1'b0;
    step(2'b00, 2'b00);

    // Reset lands while a read response is due; pointers return to 0
    rd0_valid = 1'b1; rd0_addr = 10'h3FF;
    step(2'b00, 2'b01);
    rd0_valid = 1'b0;
    rst = 1'b1;
    step(2'b00, 2'b00);
    rst = 1'b0;
    wr0_valid = 1'b1; wr0_addr = 10'h300; wr0_data = pat(32'h300);
    wr1_valid = 1'b1; wr1_addr = 10'h301; wr1_data = pat(32'h301);
    rd0_valid = 1'b1; rd0_addr = 10'h020;
    rd1_valid = 1'b1; rd1_addr = 10'h021;
    step(2'b01, 2'b01);
    wr0_valid = 1'b0; wr1_valid = 1'b0; rd0_valid = 1'b0; rd1_valid = 1'b0;
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
